// File: rtl/jtframe_ddr_romfetch.sv
// Replays a ROM image held in MiSTer DDR as a byte-wide prog_* download stream.
// Reads DDR in bursts into a local buffer, then serialises each buffer byte by byte.
module jtframe_ddr_romfetch #(
    parameter logic [28:0] DDR_BASE = 29'h0600_0000,
    parameter int          AW       = 25,
    parameter int          BURST    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] len,
    output logic          downloading,
    output logic          done,
    output logic [7:0]    ddrld_burstcnt,
    output logic [28:0]   ddrld_addr,
    output logic          ddrld_rd,
    input  logic          ddr_busy,
    input  logic [63:0]   ddr_dout,
    input  logic          ddr_dout_ready,
    output logic [AW-1:0] prog_addr,
    output logic [7:0]    prog_data,
    output logic          prog_we,
    input  logic          prog_ack
);

    localparam int KW  = (BURST > 1) ? $clog2(BURST) : 1;
    // byte index must be able to hold BURST*8 itself to detect buffer exhaustion
    localparam int BIW = KW + 4;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SER, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   len_r;
    logic [AW-1:0]   bp;
    logic [AW-4:0]   wp;
    logic [7:0]      k;
    logic [BIW-1:0]  bi;
    logic [63:0]     buffer [BURST];

    logic [AW-1:0]   bp_inc;
    logic [BIW-1:0]  bi_inc;
    logic [BIW-1:0]  burst_bytes;
    logic [AW-4:0]   wp_next;
    logic [63:0]     nxt_word;
    logic [7:0]      nxt_byte;
    logic [7:0]      first_byte;

    function automatic logic [7:0] burst_len(input logic [AW-1:0] total, input logic [AW-1:0] pos);
        logic [AW:0] words;
        words = ({1'b0, total} - {1'b0, pos} + (AW+1)'(7)) >> 3;
        if (words > (AW+1)'(BURST))
            return 8'(BURST);
        return 8'(words);
    endfunction

    assign bp_inc      = bp + 1'b1;
    assign bi_inc      = bi + 1'b1;
    assign burst_bytes = BIW'({ddrld_burstcnt, 3'b000});
    assign wp_next     = wp + (AW-3)'(ddrld_burstcnt);
    assign nxt_word    = buffer[bi_inc[KW+2:3]];
    assign nxt_byte    = nxt_word[{bi_inc[2:0], 3'b000} +: 8];
    // a single-word burst has its only word still on ddr_dout when serialisation starts
    assign first_byte  = (ddrld_burstcnt == 8'd1) ? ddr_dout[7:0] : buffer[0][7:0];

    always_ff @(posedge clk) begin
        if (state == WAIT && ddr_dout_ready)
            buffer[k[KW-1:0]] <= ddr_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            len_r          <= '0;
            bp             <= '0;
            wp             <= '0;
            k              <= '0;
            bi             <= '0;
            downloading    <= 1'b0;
            done           <= 1'b0;
            ddrld_burstcnt <= '0;
            ddrld_addr     <= '0;
            ddrld_rd       <= 1'b0;
            prog_addr      <= '0;
            prog_data      <= '0;
            prog_we        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (len != '0) begin
                            len_r          <= len;
                            wp             <= '0;
                            bp             <= '0;
                            downloading    <= 1'b1;
                            ddrld_rd       <= 1'b1;
                            ddrld_addr     <= DDR_BASE;
                            ddrld_burstcnt <= burst_len(len, '0);
                            state          <= REQ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (!ddr_busy) begin
                        ddrld_rd <= 1'b0;
                        k        <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (ddr_dout_ready) begin
                        k <= k + 8'd1;
                        if (k + 8'd1 == ddrld_burstcnt) begin
                            bi        <= '0;
                            prog_we   <= 1'b1;
                            prog_addr <= bp;
                            prog_data <= first_byte;
                            state     <= SER;
                        end
                    end
                end
                SER: begin
                    if (prog_we) begin
                        if (prog_ack) begin
                            prog_we <= 1'b0;
                            bp      <= bp_inc;
                            bi      <= bi_inc;
                            if (bp_inc == len_r) begin
                                downloading <= 1'b0;
                                done        <= 1'b1;
                                state       <= DONE;
                            end else if (bi_inc == burst_bytes) begin
                                wp             <= wp_next;
                                ddrld_addr     <= 29'(DDR_BASE + 29'(wp_next));
                                ddrld_burstcnt <= burst_len(len_r, bp_inc);
                                ddrld_rd       <= 1'b1;
                                state          <= REQ;
                            end else begin
                                prog_addr <= bp_inc;
                                prog_data <= nxt_byte;
                            end
                        end
                    end else begin
                        // one idle cycle between accepted bytes
                        prog_we <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_ddr_romfetch.sv
// Bench for jtframe_ddr_romfetch: random DDR/consumer timing, expectations from an
// arithmetic model of the request list and of the byte stream taken from a DDR content function.
module tb_jtframe_ddr_romfetch;

    localparam logic [28:0] BASE  = 29'h0600_0000;
    localparam int          AW    = 25;
    localparam int          BURST = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] len;
    logic          downloading;
    logic          done;
    logic [7:0]    ddrld_burstcnt;
    logic [28:0]   ddrld_addr;
    logic          ddrld_rd;
    logic          ddr_busy;
    logic [63:0]   ddr_dout;
    logic          ddr_dout_ready;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic          prog_we;
    logic          prog_ack;

    jtframe_ddr_romfetch #(.DDR_BASE(BASE), .AW(AW), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .downloading(downloading), .done(done),
        .ddrld_burstcnt(ddrld_burstcnt), .ddrld_addr(ddrld_addr), .ddrld_rd(ddrld_rd),
        .ddr_busy(ddr_busy), .ddr_dout(ddr_dout), .ddr_dout_ready(ddr_dout_ready),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we), .prog_ack(prog_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [28:0] addr; logic [7:0] cnt; int waited; } req_t;
    typedef struct { logic [AW-1:0] a; logic [7:0] d; } byte_t;

    req_t        req_q[$];
    byte_t       byte_q[$];
    logic [28:0] rd_q[$];

    int total = 0;
    int bad   = 0;
    int ack_mode = 0, busy_mode = 0, busy_hold = 0;
    int done_cnt = 0, rd_wait = 0, we_run = 0;
    bit saw_rd = 0, saw_dl = 0;
    logic [31:0] seed;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [28:0] a);
        logic [31:0] x;
        x = {3'b000, a};
        return {(x * 32'h9E37_79B1) ^ seed, (x * 32'h85EB_CA6B) ^ ~seed};
    endfunction

    // DDR and consumer environment: everything is observed and driven on the falling edge
    initial begin
        logic        prev_rd = 0, prev_busy = 0, prev_we = 0, prev_acc = 0, prev_done = 0, prev_rstn = 0;
        logic [28:0] prev_addr = 0;
        logic [7:0]  prev_cnt = 0, prev_pdata = 0;
        logic [AW-1:0] prev_paddr = 0;
        logic        acc;
        forever begin
            @(negedge clk);
            if (rst_n && prev_rstn) begin
                if (prev_acc)
                    check("prog_we_gap", 64'(prog_we), 64'd0);
                else if (prev_we) begin
                    check("prog_we_hold", 64'(prog_we), 64'd1);
                    check("prog_addr_hold", 64'(prog_addr), 64'(prev_paddr));
                    check("prog_data_hold", 64'(prog_data), 64'(prev_pdata));
                end
                if (prev_rd && prev_busy) begin
                    check("ddrld_rd_hold", 64'(ddrld_rd), 64'd1);
                    check("ddrld_addr_hold", 64'(ddrld_addr), 64'(prev_addr));
                    check("ddrld_cnt_hold", 64'(ddrld_burstcnt), 64'(prev_cnt));
                end
                if (done) begin
                    done_cnt++;
                    check("done_width", 64'(prev_done), 64'd0);
                end
            end
            if (downloading) saw_dl = 1;
            if (ddrld_rd) saw_rd = 1;

            case (busy_mode)
                1: ddr_busy = ($urandom_range(0, 2) == 0);
                2: if (busy_hold > 0) begin
                       ddr_busy = 1'b1;
                       if (ddrld_rd) busy_hold--;
                   end else ddr_busy = 1'b0;
                default: ddr_busy = 1'b0;
            endcase

            if (rd_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                ddr_dout       = mem_word(rd_q.pop_front());
                ddr_dout_ready = 1'b1;
            end else begin
                ddr_dout_ready = 1'b0;
                ddr_dout       = {$urandom, $urandom};
            end

            if (rst_n && ddrld_rd && !ddr_busy) begin
                req_q.push_back('{ddrld_addr, ddrld_burstcnt, rd_wait});
                for (int i = 0; i < int'(ddrld_burstcnt); i++)
                    rd_q.push_back(29'(ddrld_addr + 29'(i)));
                rd_wait = 0;
            end else if (ddrld_rd) rd_wait++;

            if (prog_we) we_run++; else we_run = 0;
            case (ack_mode)
                1:       prog_ack = (we_run >= 4);
                2:       prog_ack = 1'($urandom_range(0, 1));
                default: prog_ack = 1'b1;
            endcase
            acc = rst_n && prog_we && prog_ack;
            if (acc) byte_q.push_back('{prog_addr, prog_data});

            prev_rd = ddrld_rd;   prev_busy = ddr_busy;  prev_addr = ddrld_addr;
            prev_cnt = ddrld_burstcnt;  prev_we = prog_we;  prev_acc = acc;
            prev_paddr = prog_addr;     prev_pdata = prog_data;
            prev_done = done;           prev_rstn = rst_n;
        end
    end

    task automatic run_fetch(input int n, input int ackm, input int busym, input int hold, input bit mid_start);
        int words, nreq, off, exp_cnt, t, dc0;
        logic [63:0] w;
        req_q.delete(); byte_q.delete();
        saw_rd = 0; saw_dl = 0;
        ack_mode = ackm; busy_mode = busym; busy_hold = hold;
        dc0 = done_cnt;
        @(negedge clk); #1;
        start = 1'b1; len = AW'(n);
        @(negedge clk); #1;
        start = 1'b0;
        check("downloading_after_start", 64'(downloading), 64'(n > 0));
        if (n == 0) check("done_len0", 64'(done), 64'd1);
        t = 0;
        while (!done && t < 40000) begin
            @(negedge clk); #1;
            t++;
            if (mid_start && t == 50) begin start = 1'b1; len = AW'(3); end
            if (mid_start && t == 51) start = 1'b0;
        end
        check("done_timeout", 64'(t < 40000), 64'd1);
        check("downloading_at_done", 64'(downloading), 64'd0);
        @(negedge clk); #1;
        check("done_pulse_end", 64'(done), 64'd0);
        check("done_count", 64'(done_cnt - dc0), 64'd1);
        check("saw_rd", 64'(saw_rd), 64'(n > 0));
        check("saw_downloading", 64'(saw_dl), 64'(n > 0));

        words = (n + 7) / 8;
        nreq  = (words + BURST - 1) / BURST;
        check("req_count", 64'(req_q.size()), 64'(nreq));
        for (int i = 0; i < nreq && i < req_q.size(); i++) begin
            off     = i * BURST;
            exp_cnt = (words - off < BURST) ? words - off : BURST;
            check("req_addr", 64'(req_q[i].addr), 64'(29'(BASE + 29'(off))));
            check("req_cnt", 64'(req_q[i].cnt), 64'(exp_cnt));
        end
        check("byte_count", 64'(byte_q.size()), 64'(n));
        for (int i = 0; i < n && i < byte_q.size(); i++) begin
            w = mem_word(29'(BASE + 29'(i / 8)));
            check("byte_addr", 64'(byte_q[i].a), 64'(i));
            check("byte_data", 64'(byte_q[i].d), 64'(w[8*(i%8) +: 8]));
        end
    endtask

    initial begin
        int t;
        seed = $urandom;
        rst_n = 1'b0; start = 1'b0; len = '0;
        ddr_busy = 1'b0; ddr_dout = '0; ddr_dout_ready = 1'b0; prog_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_downloading", 64'(downloading), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ddrld_rd", 64'(ddrld_rd), 64'd0);
        check("rst_ddrld_addr", 64'(ddrld_addr), 64'd0);
        check("rst_burstcnt", 64'(ddrld_burstcnt), 64'd0);
        check("rst_prog_we", 64'(prog_we), 64'd0);
        check("rst_prog_addr", 64'(prog_addr), 64'd0);
        check("rst_prog_data", 64'(prog_data), 64'd0);
        #1 rst_n = 1'b1;

        run_fetch(16, 0, 0, 0, 0);
        run_fetch(600, 0, 0, 0, 0);
        run_fetch(40, 0, 2, 5, 0);
        check("busy_wait_cycles", 64'(req_q[0].waited), 64'd5);
        run_fetch(100, 1, 0, 0, 0);
        run_fetch(0, 0, 0, 0, 0);
        run_fetch(400, 2, 1, 0, 1);

        // reset in the middle of a burst, then a clean single-word fetch
        ack_mode = 2; busy_mode = 1;
        @(negedge clk); #1;
        start = 1'b1; len = AW'(600);
        @(negedge clk); #1;
        start = 1'b0;
        t = 0;
        while (req_q.size() == 0 && t < 1000) begin @(negedge clk); #1; t++; end
        check("mid_req_timeout", 64'(t < 1000), 64'd1);
        repeat (4) @(negedge clk);
        t = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_downloading", 64'(downloading), 64'd0);
        check("mid_rst_ddrld_rd", 64'(ddrld_rd), 64'd0);
        check("mid_rst_prog_we", 64'(prog_we), 64'd0);
        check("mid_rst_burstcnt", 64'(ddrld_burstcnt), 64'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt - t), 64'd0);
        rd_q.delete();
        run_fetch(8, 0, 0, 0, 0);

        for (int r = 0; r < 4; r++)
            run_fetch(int'($urandom_range(1, 1500)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
